// File: rtl/isqrt_iter_fsm.sv
// Iterative integer square root: y = floor(sqrt(x)) by the bit-pair restoring
// method, one result bit per clock, fixed latency of WIDTH_X/2+1 cycles.
module isqrt_iter_fsm #(
  parameter int WIDTH_X = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   x_vld,
  input  logic [WIDTH_X-1:0]     x,
  output logic                   y_vld,
  output logic [WIDTH_X/2-1:0]   y,
  output logic                   busy
);

  localparam int WIDTH_Y = WIDTH_X / 2;
  localparam int CW      = (WIDTH_Y > 1) ? $clog2(WIDTH_Y) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH_Y - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic                 accept;
  logic [WIDTH_X-1:0]   rad;
  logic [WIDTH_Y+1:0]   rem;
  logic [WIDTH_Y-1:0]   root;
  logic [CW-1:0]        count;

  logic [WIDTH_Y+3:0]   r2;
  logic [WIDTH_Y+1:0]   t;
  logic                 ge;
  logic [WIDTH_Y+1:0]   rem_next;
  logic [WIDTH_Y-1:0]   root_next;

  // One restoring iteration; r2 keeps rem's top bits so the compare sees the full value.
  always_comb begin
    r2 = {rem, rad[WIDTH_X-1 -: 2]};
    t  = {root, 2'b01};
    ge = (r2 >= {2'b00, t});
    if (ge) begin
      rem_next  = r2[WIDTH_Y+1:0] - t;
      root_next = WIDTH_Y'({root, 1'b1});
    end else begin
      rem_next  = r2[WIDTH_Y+1:0];
      root_next = WIDTH_Y'({root, 1'b0});
    end
  end

  // Next-state logic; a new operand is taken in IDLE and in the result cycle.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (x_vld) begin
          state_next = CALC;
          accept     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      CALC: begin
        if (count == LAST) begin
          state_next = DONE;
        end else begin
          state_next = CALC;
        end
      end
      DONE: begin
        if (x_vld) begin
          state_next = CALC;
          accept     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers: load on accept, iterate while calculating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rad   <= '0;
      rem   <= '0;
      root  <= '0;
      count <= '0;
    end else if (accept) begin
      rad   <= x;
      rem   <= '0;
      root  <= '0;
      count <= '0;
    end else if (state == CALC) begin
      rad   <= {rad[WIDTH_X-3:0], 2'b00};
      rem   <= rem_next;
      root  <= root_next;
      count <= count + CW'(1);
    end else begin
      rad   <= rad;
      rem   <= rem;
      root  <= root;
      count <= count;
    end
  end

  // Registered outputs, derived from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_vld <= 1'b0;
      y     <= '0;
      busy  <= 1'b0;
    end else begin
      y_vld <= (state_next == DONE);
      busy  <= (state_next == CALC);
      if ((state == CALC) && (state_next == DONE)) begin
        y <= root_next;
      end else begin
        y <= y;
      end
    end
  end

endmodule
